keypad_scanner: RTL and testbench

Scans the 4x3 launchpad key matrix and debounces the result into a stable 4-bit key code. That code drives the address select of the 12-way, 12-bit per-key value multiplexer. Key codes: 0-9 for digits, 10 for '#', 11 for '*'. The block also emits single-cycle press and release pulses for downstream tone and LED logic.

---
 rtl/keypad_pkg.sv | 27 ++
 rtl/keypad_scanner_if.sv | 22 ++
 rtl/keypad_debounce.sv | 79 +++++++
 rtl/keypad_scanner.sv | 83 ++++++++
 tb/tb_keypad_scanner.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the launchpad keypad scanner.
// key_map turns a matrix (row, column) position into the key code.
package keypad_pkg;

  localparam int unsigned KEY_CODE_W = 4;
  localparam int unsigned NUM_ROWS   = 4;
  localparam int unsigned NUM_COLS   = 3;

  localparam logic [KEY_CODE_W-1:0] KEY_HASH = 4'd10;
  localparam logic [KEY_CODE_W-1:0] KEY_STAR = 4'd11;

  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_KEY,
    CLS_MULTI
  } frame_cls_e;

  function automatic logic [KEY_CODE_W-1:0] key_map(input int unsigned r, input int unsigned c);
    logic [KEY_CODE_W-1:0] code;
    if (r < NUM_ROWS - 1)  code = KEY_CODE_W'(3 * r + c + 1);
    else if (c == 0)       code = KEY_STAR;
    else if (c == 1)       code = '0;
    else                   code = KEY_HASH;
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Matrix drive/sense and debounced key outputs of the keypad scanner.
// master = scanner side, slave = matrix/consumer side.
interface keypad_scanner_if;
  import keypad_pkg::*;

  logic [NUM_ROWS-1:0]   row_in;
  logic [NUM_COLS-1:0]   col_out;
  logic [KEY_CODE_W-1:0] key_code;
  logic                  key_valid;
  logic                  key_press;
  logic                  key_release;

  modport master (
    input  row_in,
    output col_out, key_code, key_valid, key_press, key_release
  );

  modport slave (
    output row_in,
    input  col_out, key_code, key_valid, key_press, key_release
  );
endinterface

// File: rtl/keypad_debounce.sv
// Frame-level debouncer: candidate/count/stable registers plus registered
// key outputs and single-cycle press/release pulses.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_valid,
  input  frame_cls_e            frame_cls,
  input  logic [KEY_CODE_W-1:0] frame_code,
  output logic [KEY_CODE_W-1:0] key_code,
  output logic                  key_valid,
  output logic                  key_press,
  output logic                  key_release
);

  localparam logic [7:0] DEB = 8'(DEBOUNCE);

  logic                  cand_key,    cand_key_nxt;
  logic [KEY_CODE_W-1:0] cand_code,   cand_code_nxt;
  logic [7:0]            count,       count_nxt;
  logic                  stable_key,  stable_key_nxt;
  logic [KEY_CODE_W-1:0] stable_code, stable_code_nxt;
  logic                  is_key, same;

  always_comb begin
    cand_key_nxt    = cand_key;
    cand_code_nxt   = cand_code;
    count_nxt       = count;
    stable_key_nxt  = stable_key;
    stable_code_nxt = stable_code;
    is_key = (frame_cls == CLS_KEY);
    same   = (is_key == cand_key) && (!is_key || (frame_code == cand_code));
    // MULTI frames are dropped entirely: candidate and count are untouched.
    if (frame_valid && (frame_cls != CLS_MULTI)) begin
      if (same) begin
        if (count != DEB) count_nxt = count + 8'd1;
      end else begin
        cand_key_nxt  = is_key;
        cand_code_nxt = frame_code;
        count_nxt     = 8'd1;
      end
    end
    if ((count_nxt == DEB) &&
        ((cand_key_nxt != stable_key) || (cand_key_nxt && (cand_code_nxt != stable_code)))) begin
      stable_key_nxt  = cand_key_nxt;
      stable_code_nxt = cand_code_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand_key    <= 1'b0;
      cand_code   <= '0;
      count       <= '0;
      stable_key  <= 1'b0;
      stable_code <= '0;
      key_code    <= '0;
      key_valid   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      cand_key    <= cand_key_nxt;
      cand_code   <= cand_code_nxt;
      count       <= count_nxt;
      stable_key  <= stable_key_nxt;
      stable_code <= stable_code_nxt;
      // Outputs trail the stable state by one cycle; comparing against the
      // registered outputs yields exactly one pulse per stable change.
      key_press   <= stable_key && (!key_valid || (key_code != stable_code));
      key_release <= !stable_key && key_valid;
      key_valid   <= stable_key;
      if (stable_key) key_code <= stable_code;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 keypad scanner: row synchroniser, column rotation, frame accumulation
// and classification feeding the debouncer.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic              clk,
  input  logic              rst,
  keypad_scanner_if.master  kp
);

  localparam int unsigned SLOT_W = $clog2(SCAN_DIV);
  localparam int unsigned FRAME_W = NUM_ROWS * NUM_COLS;

  logic [NUM_ROWS-1:0]   row_s1, row_s2;
  logic [SLOT_W-1:0]     slot;
  logic [1:0]            col_idx;
  logic [FRAME_W-1:0]    acc, acc_next;
  logic                  sample, frame_valid;
  logic [3:0]            ones;
  logic [KEY_CODE_W-1:0] frame_code;
  frame_cls_e            frame_cls;

  assign sample      = (slot == SLOT_W'(SCAN_DIV - 1));
  assign frame_valid = sample && (col_idx == 2'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_s1     <= '0;
      row_s2     <= '0;
      slot       <= '0;
      col_idx    <= '0;
      acc        <= '0;
      kp.col_out <= 3'b001;
    end else begin
      row_s1 <= kp.row_in;
      row_s2 <= row_s1;
      if (sample) begin
        slot       <= '0;
        col_idx    <= (col_idx == 2'd2) ? 2'd0 : col_idx + 2'd1;
        kp.col_out <= {kp.col_out[1:0], kp.col_out[2]};
        acc        <= acc_next;
      end else begin
        slot <= slot + SLOT_W'(1);
      end
    end
  end

  // Column 0 starts a fresh frame; bit index is col*NUM_ROWS + row.
  always_comb begin
    acc_next = (col_idx == 2'd0) ? '0 : acc;
    acc_next[int'(col_idx) * NUM_ROWS +: NUM_ROWS] = row_s2;
  end

  always_comb begin
    ones       = '0;
    frame_code = '0;
    for (int unsigned i = 0; i < FRAME_W; i++) begin
      if (acc_next[i]) begin
        ones       = ones + 4'd1;
        frame_code = key_map(i % NUM_ROWS, i / NUM_ROWS);
      end
    end
    if (ones == 4'd0)      frame_cls = CLS_NONE;
    else if (ones == 4'd1) frame_cls = CLS_KEY;
    else                   frame_cls = CLS_MULTI;
  end

  keypad_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
    .clk         (clk),
    .rst         (rst),
    .frame_valid (frame_valid),
    .frame_cls   (frame_cls),
    .frame_code  (frame_code),
    .key_code    (kp.key_code),
    .key_valid   (kp.key_valid),
    .key_press   (kp.key_press),
    .key_release (kp.key_release)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: directed scenarios then random key sequences,
// checked against a stable-key model with press/release counts.
module tb_keypad_scanner;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DEBOUNCE = 3;
  localparam int KM [4][3] = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}, '{11, 0, 10}};

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic [11:0] held = '0;

  int vectors = 0, errors = 0;
  int press_cnt = 0, release_cnt = 0;
  bit prev_press = 1'b0, prev_release = 1'b0;
  int m_valid = 0, m_code = 0, m_press = 0, m_release = 0;

  keypad_scanner_if kp();

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp.master)
  );

  always #5 clk = ~clk;

  // Key matrix: a held key connects its row to its column.
  always_comb begin
    kp.row_in = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (kp.col_out[c] && held[KM[r][c]]) kp.row_in[r] = 1'b1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] onehot(input int k);
    return 12'd1 << k;
  endfunction

  task automatic hold(input logic [11:0] m, input int n);
    held = m;
    repeat (n) @(negedge clk);
  endtask

  task automatic model_set(input int v, input int code);
    if (v != 0 && (m_valid == 0 || code != m_code)) m_press++;
    if (v == 0 && m_valid != 0) m_release++;
    m_valid = v;
    if (v != 0) m_code = code;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_valid"},   int'(kp.key_valid), m_valid);
    chk({tag, "_code"},    int'(kp.key_code),  m_code);
    chk({tag, "_presses"}, press_cnt,          m_press);
    chk({tag, "_releases"},release_cnt,        m_release);
  endtask

  always @(negedge clk) begin
    if (kp.key_press)   press_cnt++;
    if (kp.key_release) release_cnt++;
    chk("pulse_shape", int'((kp.key_press && kp.key_release) ||
                            (kp.key_press && prev_press) ||
                            (kp.key_release && prev_release)), 0);
    prev_press   = kp.key_press;
    prev_release = kp.key_release;
  end

  initial begin
    int lat, a, b, k;

    // Reset state and column stepping after release
    repeat (3) @(negedge clk);
    chk("rst_col", int'(kp.col_out), 1);
    check_state("rst");
    rst = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_col", int'(kp.col_out), 1);
    check_state("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("col_step", int'(kp.col_out), (i < 4) ? 1 : (i < 8) ? 2 : 4);
    end

    // Key '5': press latency, hold, release latency
    held = onehot(5);
    lat = 0;
    while (!kp.key_press && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk("press_latency", int'(kp.key_press && lat <= 52), 1);
    repeat (100 - lat) @(negedge clk);
    model_set(1, 5);
    check_state("key5");
    held = '0;
    lat = 0;
    while (!kp.key_release && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk("release_latency", int'(kp.key_release && lat <= 52), 1);
    repeat (60) @(negedge clk);
    model_set(0, 0);
    check_state("key5_off");

    // '#', '*', '0' back to back
    hold(onehot(10), 60); model_set(1, 10); check_state("hash");
    hold(onehot(11), 60); model_set(1, 11); check_state("star");
    hold(onehot(0), 60);  model_set(1, 0);  check_state("zero");
    hold('0, 60);         model_set(0, 0);  check_state("seq_off");

    // Bounce shorter than the debounce window
    hold(onehot(7), 15);
    hold('0, 60);
    check_state("bounce");

    // Two keys together, then one released
    hold(onehot(1) | onehot(9), 100); check_state("two_keys");
    hold(onehot(1), 60);  model_set(1, 1); check_state("one_left");
    hold('0, 60);         model_set(0, 0); check_state("one_off");

    // Reset while a key is held
    hold(onehot(3), 60);  model_set(1, 3); check_state("key3");
    rst = 1'b1;
    #1;
    m_valid = 0;
    m_code  = 0;
    chk("rst_press_col", int'(kp.col_out), 1);
    check_state("rst_press");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    hold(onehot(3), 60);  model_set(1, 3); check_state("key3_again");
    hold('0, 60);         model_set(0, 0); check_state("key3_off");

    // Random sequences; multi/bounce only from idle and always return to idle
    for (int s = 0; s < 24; s++) begin
      k = int'($urandom_range(0, 3));
      if (k >= 2 && m_valid != 0) k = 0;
      case (k)
        0: begin
          hold('0, 60 + int'($urandom_range(0, 15)));
          model_set(0, 0);
        end
        1: begin
          a = int'($urandom_range(0, 11));
          hold(onehot(a), 60 + int'($urandom_range(0, 15)));
          model_set(1, a);
        end
        2: begin
          a = int'($urandom_range(0, 11));
          b = (a + int'($urandom_range(1, 11))) % 12;
          hold(onehot(a) | onehot(b), 60);
          check_state("rnd_multi");
          hold('0, 60);
        end
        default: begin
          hold(onehot(int'($urandom_range(0, 11))), 15);
          hold('0, 60);
        end
      endcase
      check_state("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
